// File: rtl/infra_pkg.sv
// Shared constants for the IR line-sensor scan controller: channel map and steering codes.
package infra_pkg;

    localparam int unsigned NCH  = 3;
    localparam int unsigned CH_R = 0;
    localparam int unsigned CH_C = 1;
    localparam int unsigned CH_L = 2;

    localparam logic [1:0] DIR_STRAIGHT = 2'b00;
    localparam logic [1:0] DIR_LEFT     = 2'b01;
    localparam logic [1:0] DIR_RIGHT    = 2'b10;
    localparam logic [1:0] DIR_LOST     = 2'b11;

    // Map the {left, center, right} stable pattern onto a steering code.
    function automatic logic [1:0] dir_encode(input logic [NCH-1:0] lcr);
        logic [1:0] code;
        case (lcr)
            3'b010, 3'b111: code = DIR_STRAIGHT;
            3'b100, 3'b110: code = DIR_LEFT;
            3'b001, 3'b011: code = DIR_RIGHT;
            default:        code = DIR_LOST;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/ir_debounce.sv
// One IR channel: 2-flop synchronizer, disagreement run counter and accepted stable bit.
module ir_debounce #(
    parameter int unsigned DEB_N = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    input  logic sample_en_i,
    input  logic clear_i,
    output logic stable_o,
    output logic changed_c_o
);

    localparam int unsigned RUN_W = (DEB_N > 1) ? $clog2(DEB_N) : 1;

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic [RUN_W-1:0] run_q;
    logic [RUN_W-1:0] run_d;

    // A new value is accepted only after DEB_N consecutive disagreeing samples.
    always_comb begin
        run_d       = run_q;
        stable_d    = stable_q;
        changed_c_o = 1'b0;
        if (clear_i) begin
            run_d = '0;
        end else if (sample_en_i) begin
            if (sync2_q == stable_q) begin
                run_d = '0;
            end else if (run_q == RUN_W'(DEB_N - 1)) begin
                stable_d    = sync2_q;
                run_d       = '0;
                changed_c_o = 1'b1;
            end else begin
                run_d = run_q + RUN_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            run_q    <= '0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            run_q    <= run_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/infra_scan_ctrl.sv
// IR line-sensor scan controller: round-robin sample ticks, per-channel debounce,
// registered steering code, sticky change interrupt and change counter.
module infra_scan_ctrl
    import infra_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV = 1000,
    parameter int unsigned DEB_N      = 4,
    parameter int unsigned CNT_W      = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [NCH-1:0] ir_raw,
    input  logic           irq_ack,
    output logic [NCH-1:0] ir_stable,
    output logic [1:0]     dir,
    output logic           irq,
    output logic [7:0]     changes
);

    localparam int unsigned CH_W  = 2;
    localparam int unsigned CHG_W = 8;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CH_W-1:0]  ch_q;
    logic [CH_W-1:0]  ch_d;
    logic [1:0]       dir_q;
    logic [1:0]       dir_d;
    logic             irq_q;
    logic             irq_d;
    logic [CHG_W-1:0] changes_q;
    logic [CHG_W-1:0] changes_d;

    logic             tick_c;
    logic             accept_c;
    logic [NCH-1:0]   sample_en_c;
    logic [NCH-1:0]   changed_c;

    assign tick_c   = en && (cnt_q == CNT_W'(SAMPLE_DIV - 1));
    assign accept_c = |changed_c;

    // Only the scheduled channel samples on a tick, so at most one change per cycle.
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        assign sample_en_c[c] = tick_c && (ch_q == CH_W'(c));

        ir_debounce #(
            .DEB_N(DEB_N)
        ) u_deb (
            .clk        (clk),
            .rst        (rst),
            .raw_i      (ir_raw[c]),
            .sample_en_i(sample_en_c[c]),
            .clear_i    (!en),
            .stable_o   (ir_stable[c]),
            .changed_c_o(changed_c[c])
        );
    end

    always_comb begin
        cnt_d     = cnt_q;
        ch_d      = ch_q;
        irq_d     = irq_q;
        changes_d = changes_q + CHG_W'(accept_c);
        dir_d     = dir_encode({ir_stable[CH_L], ir_stable[CH_C], ir_stable[CH_R]});

        if (!en) begin
            cnt_d = '0;
            ch_d  = '0;
        end else if (tick_c) begin
            cnt_d = '0;
            ch_d  = (ch_q == CH_W'(NCH - 1)) ? '0 : ch_q + CH_W'(1);
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // A new accepted change outranks a simultaneous acknowledge.
        if (accept_c) begin
            irq_d = 1'b1;
        end else if (irq_ack) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            ch_q      <= '0;
            dir_q     <= DIR_LOST;
            irq_q     <= 1'b0;
            changes_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            ch_q      <= ch_d;
            dir_q     <= dir_d;
            irq_q     <= irq_d;
            changes_q <= changes_d;
        end
    end

    assign dir     = dir_q;
    assign irq     = irq_q;
    assign changes = changes_q;

endmodule
